mem_ctrl_wait: RTL and testbench

Parametrised byte-addressed main-memory controller, the successor to the datapath's fixed 16-bit main memory. It adds configurable data and address width, a req/ready/ack handshake, per-byte write enables and little-endian unaligned access with address wrap-around. It also adds programmable wait states and a sequenced post-reset clear, replacing the single-cycle clear. It sits between the datapath's load/store unit and the memory array, and owns the array.

---
 rtl/mem_ctrl_wait.sv | 153 +++++++++++++++
 tb/tb_mem_ctrl_wait.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_wait.sv
// Byte-addressed main-memory controller with req/ready/ack handshake,
// programmable wait states, per-byte enables, little-endian unaligned
// access with address wrap, and a sequenced post-reset array clear.
module mem_ctrl_wait #(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [DATA_W-1:0] INIT_WORD   = 16'h2BCD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic                ack,
  output logic [DATA_W-1:0]   rdata
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned SH    = $clog2(BYTES);
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH / BYTES - 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BYTES-1:0]    be_q, be_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [7:0]          mem_q [DEPTH];

  logic [ADDR_W-1:0]   lane_addr [BYTES];
  logic [7:0]          lane_data [BYTES];
  logic [BYTES-1:0]    lane_we;
  logic [DATA_W-1:0]   rd_word;

  assign ready = (state_q == ST_IDLE);
  assign ack   = ack_q;
  assign rdata = rdata_q;

  // Per-lane byte address, write data and enable; the clear sequence and
  // the latched access share the same lane ports into the array. Writes are
  // gated by rst so an access cut by reset never lands partially.
  always_comb begin
    lane_we = '0;
    rd_word = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      lane_addr[i] = '0;
      lane_data[i] = '0;
      if (state_q == ST_CLEAR) begin
        lane_addr[i] = (ptr_q << SH) + ADDR_W'(i);
        lane_data[i] = (ptr_q == '0) ? INIT_WORD[8*i +: 8] : 8'h00;
        lane_we[i]   = rst;
      end else begin
        lane_addr[i] = addr_q + ADDR_W'(i);
        lane_data[i] = wdata_q[8*i +: 8];
        lane_we[i]   = rst && (state_q == ST_WAIT) && (cnt_q == '0) && we_q && be_q[i];
      end
      rd_word[8*i +: 8] = mem_q[lane_addr[i]];
    end
  end

  // Byte array; contents are not reset, only overwritten by the clear walk.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (lane_we[i]) mem_q[lane_addr[i]] <= lane_data[i];
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state: clear walk, accept/latch in IDLE, wait countdown then access.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      ST_CLEAR: begin
        if (ptr_q == LAST_PTR) begin
          ptr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = be;
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ack_d   = 1'b1;
          state_d = ST_IDLE;
          if (!we_q) rdata_d = rd_word;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl_wait.sv
// Self-checking bench for mem_ctrl_wait: directed scenarios plus random
// accesses checked against a byte-array reference model.
module tb_mem_ctrl_wait;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req0, we;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [1:0]  be;
  logic        ready, ack, ready0, ack0;
  logic [15:0] rdata, rdata0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem [256];
  logic [15:0] last_rd;
  logic [15:0] rd;

  mem_ctrl_wait #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC), .INIT_WORD(16'h2BCD)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready), .ack(ack), .rdata(rdata)
  );

  mem_ctrl_wait #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0), .INIT_WORD(16'h2BCD)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready0), .ack(ack0), .rdata(rdata0)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_read(input logic [7:0] a);
    logic [7:0] a1;
    a1 = a + 8'd1;
    return {ref_mem[a1], ref_mem[a]};
  endfunction

  task automatic ref_write(input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
    logic [7:0] ai;
    for (int i = 0; i < 2; i++) begin
      ai = a + 8'(i);
      if (b[i]) ref_mem[ai] = d[8*i +: 8];
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_mem[0] = 8'hCD;
    ref_mem[1] = 8'h2B;
    last_rd = 16'h0000;
  endtask

  // Assert reset, release it and follow the clear sequence edge by edge.
  task automatic do_reset();
    int bad;
    rst = 1'b0;
    req = 1'b0;
    req0 = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 32'(0));
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int k = 1; k <= 128; k++) begin
      @(posedge clk); #1;
      if (k < 128 && (ready !== 1'b0 || ack !== 1'b0 || rdata !== 16'h0 || ready0 !== 1'b0))
        bad++;
    end
    chk("clear_quiet", 32'(bad), 32'(0));
    chk("ready_after_clear", 32'(ready), 32'(1));
    chk("ready0_after_clear", 32'(ready0), 32'(1));
    ref_clear();
  endtask

  // One access on the WAIT_CYCLES=2 instance; called at posedge+1.
  task automatic access(input logic w, input logic [7:0] a, input logic [15:0] d,
                        input logic [1:0] b, output logic [15:0] rd_o);
    int lat;
    logic [15:0] exp;
    chk("ready_idle", 32'(ready), 32'(1));
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    chk("busy_after_accept", 32'(ready), 32'(0));
    req = 1'b0;
    we = 1'($urandom); addr = 8'($urandom); wdata = 16'($urandom); be = 2'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (ack !== 1'b1 && lat < 20);
    chk("latency", 32'(lat), 32'(WC + 1));
    if (w) begin
      ref_write(a, d, b);
      chk("rdata_hold", 32'(rdata), 32'(last_rd));
    end else begin
      exp = ref_read(a);
      chk("read_data", 32'(rdata), 32'(exp));
      last_rd = exp;
    end
    rd_o = rdata;
    @(posedge clk); #1;
    chk("ack_single", 32'(ack), 32'(0));
  endtask

  initial begin
    int acks, p1, p2;
    logic [15:0] d1, d2, e1, e2;
    logic        w;
    logic [7:0]  a;

    rst = 1'b0; req = 1'b0; req0 = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; be = '0;
    ref_clear();
    @(posedge clk); #1;
    do_reset();

    // Clear contents
    access(1'b0, 8'h00, 16'h0, 2'b00, rd);
    chk("init_word", 32'(rd), 32'h2BCD);
    access(1'b0, 8'h02, 16'h0, 2'b00, rd);
    chk("cleared_word", 32'(rd), 32'h0000);

    // Latency and basic write/read
    access(1'b1, 8'h10, 16'hBEEF, 2'b11, rd);
    access(1'b0, 8'h10, 16'h0, 2'b00, rd);
    chk("beef", 32'(rd), 32'hBEEF);

    // Zero wait-state instance
    chk("ready0_idle", 32'(ready0), 32'(1));
    req0 = 1'b1; we = 1'b1; addr = 8'h10; wdata = 16'hBEEF; be = 2'b11;
    @(posedge clk); #1;
    req0 = 1'b0;
    chk("w0_no_ack_at_accept", 32'(ack0), 32'(0));
    @(posedge clk); #1;
    chk("w0_ack", 32'(ack0), 32'(1));
    req0 = 1'b1; we = 1'b0; addr = 8'h10;
    @(posedge clk); #1;
    req0 = 1'b0;
    @(posedge clk); #1;
    chk("r0_ack", 32'(ack0), 32'(1));
    chk("r0_data", 32'(rdata0), 32'hBEEF);
    @(posedge clk); #1;
    chk("r0_ack_drop", 32'(ack0), 32'(0));

    // Byte enables and unaligned read
    access(1'b1, 8'h20, 16'h1234, 2'b11, rd);
    access(1'b1, 8'h20, 16'hAA55, 2'b01, rd);
    access(1'b0, 8'h20, 16'h0, 2'b00, rd);
    chk("be_merge", 32'(rd), 32'h1255);
    access(1'b0, 8'h21, 16'h0, 2'b00, rd);
    chk("unaligned", 32'(rd), 32'h0012);
    access(1'b1, 8'h30, 16'hFFFF, 2'b00, rd);
    access(1'b0, 8'h30, 16'h0, 2'b00, rd);
    chk("be_zero", 32'(rd), 32'h0000);

    // Wrap-around
    access(1'b1, 8'hFF, 16'hA1B2, 2'b11, rd);
    access(1'b0, 8'h00, 16'h0, 2'b00, rd);
    chk("wrap_low", 32'(rd), 32'h2BA1);
    access(1'b0, 8'hFF, 16'h0, 2'b00, rd);
    chk("wrap_full", 32'(rd), 32'hA1B2);

    // Back-to-back with req held; second request's fields set during the first WAIT
    req = 1'b1; we = 1'b0; addr = 8'h20; wdata = 16'h0; be = 2'b00;
    e1 = ref_read(8'h20);
    e2 = ref_read(8'h00);
    @(posedge clk); #1;
    addr = 8'h00;
    acks = 0; p1 = 0; p2 = 0; d1 = '0; d2 = '0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin
        acks++;
        if (acks == 1) begin p1 = k; d1 = rdata; end
        else begin p2 = k; d2 = rdata; end
      end
      if (k == 4) begin
        chk("b2b_accept", 32'(ready), 32'(0));
        req = 1'b0;
      end
    end
    chk("b2b_acks", 32'(acks), 32'(2));
    chk("b2b_pos1", 32'(p1), 32'(WC + 1));
    chk("b2b_pos2", 32'(p2), 32'(2 * (WC + 1) + 1));
    chk("b2b_data1", 32'(d1), 32'(e1));
    chk("b2b_data2", 32'(d2), 32'(e2));
    last_rd = e2;

    // Random traffic against the model
    for (int n = 0; n < 60; n++) begin
      w = 1'($urandom);
      a = (n % 5 == 0) ? 8'hFF : 8'($urandom);
      access(w, a, 16'($urandom), 2'($urandom), rd);
    end

    // Reset during WAIT of a write
    req = 1'b1; we = 1'b1; addr = 8'h40; wdata = 16'hFFFF; be = 2'b11;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    do_reset();
    access(1'b0, 8'h40, 16'h0, 2'b00, rd);
    chk("abandoned_write", 32'(rd), 32'h0000);
    access(1'b0, 8'h00, 16'h0, 2'b00, rd);
    chk("init_after_rst", 32'(rd), 32'h2BCD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
